divider: RTL and testbench

//  Unsigned 32/32 sequential shift-subtract (restoring) divider: the inverse of the

---
 rtl/divider_if.sv | 30 +++
 rtl/divider.sv | 111 +++++++++++
 tb/tb_divider.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
//------------------------------------------------------------------------------
// Module  : divider_if
// Brief   : Operand, control and result bundle for the sequential divider.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  logic [5:0]         Signal;
  logic [2*WIDTH-1:0] dataOut;
  logic               busy;
  logic               done;
  logic               divZero;

  modport master (
    output dataA, dataB, Signal,
    input  dataOut, busy, done, divZero
  );

  modport slave (
    input  dataA, dataB, Signal,
    output dataOut, busy, done, divZero
  );
endinterface

`default_nettype wire

// File: rtl/divider.sv
//------------------------------------------------------------------------------
// Module  : divider
// Brief   : Unsigned WIDTH/WIDTH restoring divider, one iteration per clock,
//           result packed as {remainder, quotient}.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divider #(
  parameter int         WIDTH = 32,
  parameter logic [5:0] DIVU  = 6'b011011,
  parameter logic [5:0] OUT   = 6'b111111
) (
  input  logic      clk,
  input  logic      reset,
  divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q;
  logic [2*WIDTH-1:0] work_q;
  logic [2*WIDTH-1:0] work_d;
  logic [WIDTH-1:0]   divisor_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] dataout_q;
  logic               busy_q;
  logic               done_q;
  logic               divzero_q;

  logic [WIDTH:0]     part_w;
  logic [WIDTH:0]     diff_w;
  logic               fits_w;
  logic               start_w;
  logic               release_w;

  // The top half after the shift, including the bit shifted out, is compared
  // WIDTH+1 bits wide so a remainder with its MSB set never overflows.
  always_comb begin
    part_w = work_q[2*WIDTH-1:WIDTH-1];
    diff_w = part_w - {1'b0, divisor_q};
    fits_w = (part_w >= {1'b0, divisor_q});
    work_d = {work_q[2*WIDTH-2:0], 1'b0};
    if (fits_w) begin
      work_d[2*WIDTH-1:WIDTH] = diff_w[WIDTH-1:0];
      work_d[0]               = 1'b1;
    end
  end

  assign start_w   = (bus.Signal == DIVU);
  assign release_w = (bus.Signal == OUT) || (bus.Signal != DIVU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      work_q    <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      dataout_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_w) begin
            divisor_q <= bus.dataB;
            work_q    <= {{WIDTH{1'b0}}, bus.dataA};
            count_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          work_q  <= work_d;
          count_q <= count_q + CW'(1);
          if (count_q == LAST) begin
            dataout_q <= work_d;
            divzero_q <= (divisor_q == '0);
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // Holding DIVU here must not retrigger; a new start needs IDLE first.
          if (release_w) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dataOut = dataout_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divZero = divzero_q;

endmodule

`default_nettype wire

// File: tb/tb_divider.sv
//------------------------------------------------------------------------------
// Module  : tb_divider
// Brief   : Directed and randomized self-checking bench for the divider.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_divider;

  localparam logic [5:0] DIVU = 6'b011011;
  localparam logic [5:0] OUT  = 6'b111111;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  divider_if #(.WIDTH(32)) bus ();

  divider #(.WIDTH(32), .DIVU(DIVU), .OUT(OUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a divide, optionally disturb the inputs at edge chg, check the
  // 32-edge latency, the result and the release back to IDLE.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int chg, input string tag);
    logic [63:0] exp;
    logic [63:0] prev;
    logic        bad;
    exp        = model(a, b);
    bus.dataA  = a;
    bus.dataB  = b;
    bus.Signal = DIVU;
    prev       = bus.dataOut;
    tick();
    bus.Signal = OUT;
    chk({tag, "_busy_E0"}, 64'(bus.busy), 64'd1);
    bad = 1'b0;
    for (int e = 1; e < 32; e++) begin
      if (e == chg) begin
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
        bus.Signal = DIVU;
      end else begin
        bus.Signal = OUT;
      end
      tick();
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.dataOut !== prev) bad = 1'b1;
    end
    bus.Signal = OUT;
    chk({tag, "_run_stable"}, 64'(bad), 64'd0);
    tick();
    chk({tag, "_result"}, bus.dataOut, exp);
    chk({tag, "_flags"}, {61'd0, bus.busy, bus.done, bus.divZero}, {61'd0, 1'b0, 1'b1, (b == 32'd0)});
    tick();
    chk({tag, "_release"}, {bus.dataOut, 63'd0, bus.done}, {exp, 64'd0});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] held;
    logic        bad;
    tests      = 0;
    failed     = 0;
    reset      = 1'b1;
    bus.dataA  = '0;
    bus.dataB  = '0;
    bus.Signal = OUT;
    tick();
    chk("reset_state", {bus.dataOut}, 64'd0);
    chk("reset_flags", {61'd0, bus.busy, bus.done, bus.divZero}, 64'd0);
    reset = 1'b0;
    tick();

    run_div(32'd100, 32'd7, 0, "t1_100_7");
    chk("t1_const", bus.dataOut, 64'h00000002_0000000E);
    run_div(32'hFFFF_FFFF, 32'd1, 0, "t2_max_1");
    run_div(32'd3, 32'd10, 0, "t2_small");
    run_div(32'd5, 32'd0, 0, "t3_divzero");
    run_div(32'd0, 32'd9, 0, "zero_dividend");

    // Asynchronous reset in the middle of a run.
    bus.dataA  = 32'd100;
    bus.dataB  = 32'd7;
    bus.Signal = DIVU;
    tick();
    bus.Signal = OUT;
    for (int e = 1; e <= 10; e++) tick();
    #2 reset = 1'b1;
    #1;
    chk("t4_abort", {bus.dataOut[61:0], bus.busy, bus.done}, 64'd0);
    chk("t4_abort_hi", {62'd0, bus.dataOut[63:62]}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    run_div(32'd100, 32'd7, 0, "t4_rerun");

    // Hold DIVU through DONE: no restart.
    bus.dataA  = 32'd100;
    bus.dataB  = 32'd7;
    bus.Signal = DIVU;
    for (int e = 0; e <= 32; e++) tick();
    held = bus.dataOut;
    chk("t5_done", {bus.dataOut, 62'd0, bus.done, bus.busy}, {64'h00000002_0000000E, 64'd2});
    bus.dataA = 32'd9;
    bus.dataB = 32'd3;
    bad = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.dataOut !== held) bad = 1'b1;
    end
    chk("t5_no_restart", 64'(bad), 64'd0);
    bus.Signal = OUT;
    tick();
    run_div(32'd9, 32'd3, 0, "t5_9_3");

    run_div(32'd100, 32'd7, 5, "t6_disturb");

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      case (i % 3)
        0:       rb = $urandom_range(1, 255);
        1:       rb = $urandom;
        default: rb = ra >> $urandom_range(0, 31);
      endcase
      run_div(ra, rb, 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
